// File: rtl/usb_sie_tx.sv
// USB FS link transmitter: serialises PID, payload and CRC16 onto the UTMI transmit port.
// Optional PID/type legality check is enabled by defining USB_SIE_TX_PID_CHECK_EN.
module usb_sie_tx #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pkt_pid,
    input  logic       pkt_has_data,
    input  logic       pkt_zlp,
    input  logic       pkt_start,
    input  logic [7:0] pld_data,
    input  logic       pld_valid,
    input  logic       pld_last,
    output logic       pld_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] utmi_data_in,
    output logic       utmi_tx_valid,
    input  logic       utmi_tx_ready
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PID    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CRC_LO = 3'd3;
    localparam logic [2:0] S_CRC_HI = 3'd4;

    logic [2:0]    state, state_nx;
    logic [3:0]    pid_q;
    logic          has_data_q, zlp_q;
    logic          ovl_q, ovl_nx;
    logic [15:0]   crc, crc_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          done_nx, err_nx;
    logic          pid_ok;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic [7:0]  dd;
        r  = c;
        dd = d;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ dd[0]) r = (r >> 1) ^ 16'hA001;
            else              r = r >> 1;
            dd = dd >> 1;
        end
        return r;
    endfunction

`ifdef USB_SIE_TX_PID_CHECK_EN
    assign pid_ok = pkt_has_data ? (pkt_pid == 4'h3 || pkt_pid == 4'hB)
                                 : (pkt_pid == 4'h2 || pkt_pid == 4'hA || pkt_pid == 4'hE);
`else
    assign pid_ok = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        crc_nx   = crc;
        cnt_nx   = cnt;
        ovl_nx   = ovl_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pkt_start) begin
                    if (pid_ok) begin
                        state_nx = S_PID;
                        crc_nx   = 16'hFFFF;
                        cnt_nx   = '0;
                        ovl_nx   = 1'b0;
                    end else begin
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end
                end
            end
            S_PID: begin
                if (utmi_tx_ready) begin
                    if (!has_data_q) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else if (zlp_q) begin
                        state_nx = S_CRC_LO;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (utmi_tx_ready) begin
                    // Missing byte while the UTM wants one: abort, the short CRC marks it bad.
                    if (!pld_valid) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                        err_nx   = 1'b1;
                    end else begin
                        crc_nx = crc16_byte(crc, pld_data);
                        cnt_nx = cnt + CW'(1);
                        if (pld_last) begin
                            state_nx = S_CRC_LO;
                        end else if (cnt_nx == CW'(MAX_PAYLOAD)) begin
                            state_nx = S_CRC_LO;
                            ovl_nx   = 1'b1;
                        end
                    end
                end
            end
            S_CRC_LO: begin
                if (utmi_tx_ready) state_nx = S_CRC_HI;
            end
            S_CRC_HI: begin
                if (utmi_tx_ready) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                    err_nx   = ovl_q;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pid_q      <= '0;
            has_data_q <= 1'b0;
            zlp_q      <= 1'b0;
            ovl_q      <= 1'b0;
            crc        <= 16'hFFFF;
            cnt        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == S_IDLE && pkt_start) begin
                pid_q      <= pkt_pid;
                has_data_q <= pkt_has_data;
                zlp_q      <= pkt_zlp;
            end
            state <= state_nx;
            ovl_q <= ovl_nx;
            crc   <= crc_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

    assign busy          = (state != S_IDLE);
    assign utmi_tx_valid = busy;
    assign pld_ready     = (state == S_DATA) & utmi_tx_ready & pld_valid;

    always_comb begin
        case (state)
            S_PID:    utmi_data_in = {~pid_q, pid_q};
            S_DATA:   utmi_data_in = pld_data;
            S_CRC_LO: utmi_data_in = ~crc[7:0];
            S_CRC_HI: utmi_data_in = ~crc[15:8];
            default:  utmi_data_in = '0;
        endcase
    end

endmodule

// File: tb/tb_usb_sie_tx.sv
// Directed bench for usb_sie_tx: table of packets plus hand sequences for gap and async reset.
module tb_usb_sie_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] pkt_pid;
    logic       pkt_has_data, pkt_zlp, pkt_start;
    logic [7:0] pld_data;
    logic       pld_valid, pld_last, utmi_tx_ready;
    logic       sel;

    logic       start_a, start_b;
    logic       pld_ready_a, busy_a, done_a, err_a, txv_a;
    logic       pld_ready_b, busy_b, done_b, err_b, txv_b;
    logic [7:0] data_a, data_b;

    assign start_a = pkt_start & ~sel;
    assign start_b = pkt_start & sel;

    logic       pld_ready, busy, done, err, txv;
    logic [7:0] data_in;
    assign pld_ready = sel ? pld_ready_b : pld_ready_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign done      = sel ? done_b      : done_a;
    assign err       = sel ? err_b       : err_a;
    assign txv       = sel ? txv_b       : txv_a;
    assign data_in   = sel ? data_b      : data_a;

    usb_sie_tx dut_a (
        .clk(clk), .rst(rst), .pkt_pid(pkt_pid), .pkt_has_data(pkt_has_data),
        .pkt_zlp(pkt_zlp), .pkt_start(start_a), .pld_data(pld_data), .pld_valid(pld_valid),
        .pld_last(pld_last), .pld_ready(pld_ready_a), .busy(busy_a), .done(done_a), .err(err_a),
        .utmi_data_in(data_a), .utmi_tx_valid(txv_a), .utmi_tx_ready(utmi_tx_ready)
    );

    usb_sie_tx #(.MAX_PAYLOAD(4)) dut_b (
        .clk(clk), .rst(rst), .pkt_pid(pkt_pid), .pkt_has_data(pkt_has_data),
        .pkt_zlp(pkt_zlp), .pkt_start(start_b), .pld_data(pld_data), .pld_valid(pld_valid),
        .pld_last(pld_last), .pld_ready(pld_ready_b), .busy(busy_b), .done(done_b), .err(err_b),
        .utmi_data_in(data_b), .utmi_tx_valid(txv_b), .utmi_tx_ready(utmi_tx_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  pid;
        logic        hd;
        logic        zlp;
        int          n;
        logic        use_last;
        logic        alt_ready;
        int          underrun;
        logic        hold;
        logic        use_b;
        int          exp_n;
        logic [95:0] exp_bytes;
        logic        exp_err;
        int          exp_rdy;
    } vec_t;

    logic [7:0] payload [16];

    // Independent CRC-16/USB reference over payload bytes 0x31, 0x32, ...
    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = 8'h31 + 8'(k);
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        logic [7:0] got[$];
        logic [7:0] prev;
        int  idx, rdy, stab_bad;
        bit  seen_done, stall_prev;
        logic d_err, d_txv, d_busy;
        idx = 0; rdy = 0; stab_bad = 0; seen_done = 0; stall_prev = 0; prev = '0;
        d_err = 1'bx; d_txv = 1'b1; d_busy = 1'b1;
        sel = v.use_b;
        @(negedge clk);
        pkt_pid = v.pid; pkt_has_data = v.hd; pkt_zlp = v.zlp; pkt_start = 1'b1;
        utmi_tx_ready = 1'b1; pld_valid = 1'b0; pld_last = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            @(negedge clk);
            pkt_start = v.hold && cyc < 3;
            if (v.hold) begin
                pkt_pid = 4'h2; pkt_has_data = 1'b0;
            end
            utmi_tx_ready = v.alt_ready ? (cyc % 2 == 0) : 1'b1;
            pld_valid = (idx < v.n) && (v.underrun < 0 || idx < v.underrun);
            pld_data  = payload[idx];
            pld_last  = v.use_last && (idx == v.n - 1);
            #1;
            if (txv && utmi_tx_ready) got.push_back(data_in);
            if (stall_prev && data_in !== prev) stab_bad++;
            stall_prev = txv && !utmi_tx_ready;
            prev = data_in;
            if (pld_ready) begin
                rdy++; idx++;
            end
            if (done) begin
                seen_done = 1; d_err = err; d_txv = txv; d_busy = busy;
            end
        end
        pkt_start = 1'b0; pld_valid = 1'b0; pld_last = 1'b0;
        chk($sformatf("v%0d_done_seen", id), 32'(seen_done), 32'd1);
        chk($sformatf("v%0d_nbytes", id), 32'(got.size()), 32'(v.exp_n));
        for (int k = 0; k < v.exp_n && k < got.size(); k++)
            chk($sformatf("v%0d_byte%0d", id, k), 32'(got[k]), 32'(v.exp_bytes[95-8*k -: 8]));
        chk($sformatf("v%0d_err", id), 32'(d_err), 32'(v.exp_err));
        chk($sformatf("v%0d_txv_at_done", id), 32'(d_txv), 32'd0);
        chk($sformatf("v%0d_busy_at_done", id), 32'(d_busy), 32'd0);
        chk($sformatf("v%0d_pld_ready_cnt", id), 32'(rdy), 32'(v.exp_rdy));
        if (v.alt_ready) chk($sformatf("v%0d_stall_stable", id), 32'(stab_bad), 32'd0);
        @(negedge clk);
        #1 chk($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
    endtask

    localparam logic [95:0] DATA123 = {8'hC3, 72'h313233343536373839, 8'hC8, 8'hB4};

    vec_t vecs [11];

    initial begin
        logic [15:0] m;
        for (int k = 0; k < 16; k++) payload[k] = 8'h31 + 8'(k);
        m = ~ref_crc(4);
        //            pid    hd    zlp   n  last  alt   und  hold  b    en  bytes                           err   rdy
        vecs[0]  = '{4'h2, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1, {8'hD2, 88'h0},               1'b0, 0};
        vecs[1]  = '{4'h3, 1'b1, 1'b0, 9, 1'b1, 1'b0, -1, 1'b0, 1'b0, 12, DATA123,                     1'b0, 9};
        vecs[2]  = '{4'hB, 1'b1, 1'b1, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 3, {24'h4B0000, 72'h0},          1'b0, 0};
        vecs[3]  = '{4'h3, 1'b1, 1'b0, 9, 1'b1, 1'b1, -1, 1'b0, 1'b0, 12, DATA123,                     1'b0, 9};
        vecs[4]  = '{4'h3, 1'b1, 1'b0, 9, 1'b1, 1'b0, 2,  1'b0, 1'b0, 4, {32'hC3313233, 64'h0},        1'b1, 2};
        vecs[5]  = '{4'h2, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1, {8'hD2, 88'h0},               1'b0, 0};
        vecs[6]  = '{4'h3, 1'b1, 1'b0, 9, 1'b1, 1'b0, -1, 1'b1, 1'b0, 12, DATA123,                     1'b0, 9};
        vecs[7]  = '{4'hA, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1, {8'h5A, 88'h0},               1'b0, 0};
        vecs[8]  = '{4'hE, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1, {8'h1E, 88'h0},               1'b0, 0};
        vecs[9]  = '{4'h3, 1'b1, 1'b0, 6, 1'b0, 1'b0, -1, 1'b0, 1'b1, 7, {40'hC331323334, m[7:0], m[15:8], 40'h0}, 1'b1, 4};
`ifdef USB_SIE_TX_PID_CHECK_EN
        vecs[10] = '{4'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 0, 96'h0,                        1'b1, 0};
`else
        vecs[10] = '{4'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1, {8'hE1, 88'h0},               1'b0, 0};
`endif

        rst = 1'b0; sel = 1'b0; pkt_pid = '0; pkt_has_data = 1'b0; pkt_zlp = 1'b0; pkt_start = 1'b0;
        pld_data = '0; pld_valid = 1'b0; pld_last = 1'b0; utmi_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txv", 32'(txv), 32'd0);
        chk("rst_data", 32'(data_in), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pld_ready", 32'(pld_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Back-to-back: a start in the done cycle gives a single idle cycle between packets
        sel = 1'b0;
        @(negedge clk);
        pkt_pid = 4'h2; pkt_has_data = 1'b0; pkt_zlp = 1'b0; pkt_start = 1'b1; utmi_tx_ready = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        #1 chk("b2b_first_txv", 32'(txv), 32'd1);
        chk("b2b_first_data", 32'(data_in), 32'hD2);
        @(negedge clk);
        pkt_pid = 4'hA; pkt_start = 1'b1;
        #1 chk("b2b_gap_done", 32'(done), 32'd1);
        chk("b2b_gap_txv", 32'(txv), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        pkt_start = 1'b0;
        #1 chk("b2b_second_txv", 32'(txv), 32'd1);
        chk("b2b_second_data", 32'(data_in), 32'h5A);
        @(negedge clk);
        #1 chk("b2b_second_done", 32'(done), 32'd1);

`ifdef USB_SIE_TX_PID_CHECK_EN
        @(negedge clk);
        pkt_pid = 4'h2; pkt_has_data = 1'b1; pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        #1 chk("badtype_done", 32'(done), 32'd1);
        chk("badtype_err", 32'(err), 32'd1);
        chk("badtype_txv", 32'(txv), 32'd0);
`endif

        // Asynchronous reset in the middle of a data packet
        @(negedge clk);
        pkt_pid = 4'h3; pkt_has_data = 1'b1; pkt_zlp = 1'b0; pkt_start = 1'b1;
        pld_valid = 1'b1; pld_data = 8'h31; pld_last = 1'b0; utmi_tx_ready = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("arst_pre_txv", 32'(txv), 32'd1);
        #1 rst = 1'b0;
        #1 chk("arst_txv", 32'(txv), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        pld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk($sformatf("arst_no_done%0d", c), 32'(done), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
